// File: rtl/lane_phase_sequencer.sv
// Density-driven GREEN/YELLOW/ALLRED sequencer for a 4-lane junction.
// Drives the downstream 4:1 lane mux select and the per-lane lamps, with emergency override.
module lane_phase_sequencer #(
  parameter int TW       = 8,
  parameter int T_MIN    = 4,
  parameter int T_EXT    = 2,
  parameter int T_YELLOW = 2,
  parameter int T_ALLRED = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] den1,
  input  logic [1:0] den2,
  input  logic [1:0] den3,
  input  logic [1:0] den4,
  input  logic       emg_req,
  input  logic [1:0] emg_lane,
  output logic [1:0] sel,
  output logic [3:0] grn,
  output logic [3:0] yel,
  output logic [3:0] red,
  output logic [1:0] phase,
  output logic       emg_act
);

  typedef enum logic [1:0] {
    ALLRED = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10
  } phase_e;

  typedef struct packed {
    logic [3:0] grn;
    logic [3:0] yel;
    logic [3:0] red;
  } lamps_t;

  localparam logic [TW-1:0] YELLOW_LOAD = TW'(T_YELLOW - 1);
  localparam logic [TW-1:0] ALLRED_LOAD = TW'(T_ALLRED - 1);
  localparam lamps_t        LAMPS_RESET = '{grn: 4'h0, yel: 4'h0, red: 4'hF};

  phase_e        state;
  logic [TW-1:0] timer;
  lamps_t        lamps;
  logic [1:0]    den [4];
  logic [1:0]    rr_lane;
  logic [1:0]    next_lane;
  logic [TW-1:0] green_load;
  logic          hold;
  logic          trunc;
  logic          green_done;

  function automatic lamps_t decode(input phase_e p, input logic [1:0] lane);
    logic [3:0] onehot;
    onehot = 4'b0001 << lane;
    case (p)
      GREEN:   decode = '{grn: onehot, yel: 4'h0, red: ~onehot};
      YELLOW:  decode = '{grn: 4'h0, yel: onehot, red: ~onehot};
      default: decode = LAMPS_RESET;
    endcase
  endfunction

  always_comb begin
    den[0] = den1;
    den[1] = den2;
    den[2] = den3;
    den[3] = den4;
  end

  // Scan from the farthest candidate down so the nearest non-empty lane wins;
  // offset 4 wraps to the current lane, which is therefore considered last.
  // NOTE: rr_lane gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    rr_lane = sel + 2'd1;
    for (int i = 4; i >= 1; i--) begin
      if (den[sel + 2'(i)] != 2'd0) rr_lane = sel + 2'(i);
    end
  end

  assign next_lane  = emg_req ? emg_lane : rr_lane;
  assign green_load = TW'(T_MIN) + TW'(den[next_lane]) * TW'(T_EXT) - TW'(1);

  // Emergency on the lane being served pins green; emergency elsewhere cuts a normal green short.
  assign hold       = emg_req && (emg_act || emg_lane == sel);
  assign trunc      = emg_req && !emg_act && emg_lane != sel;
  assign green_done = trunc || (timer == '0 && !hold);

  // NOTE: all state in this block uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ALLRED;
      sel     <= 2'b11;
      timer   <= ALLRED_LOAD;
      emg_act <= 1'b0;
      lamps   <= LAMPS_RESET;
    end else begin
      case (state)
        ALLRED: begin
          if (timer == '0) begin
            state   <= GREEN;
            sel     <= next_lane;
            timer   <= green_load;
            emg_act <= emg_req;
            lamps   <= decode(GREEN, next_lane);
          end else begin
            timer <= timer - TW'(1);
          end
        end
        GREEN: begin
          if (green_done) begin
            state   <= YELLOW;
            timer   <= YELLOW_LOAD;
            emg_act <= 1'b0;
            lamps   <= decode(YELLOW, sel);
          end else begin
            // Timer saturates at zero so an emergency hold still enforces the minimum green.
            if (timer != '0) timer <= timer - TW'(1);
            if (emg_req && emg_lane == sel) emg_act <= 1'b1;
          end
        end
        YELLOW: begin
          if (timer == '0) begin
            state <= ALLRED;
            timer <= ALLRED_LOAD;
            lamps <= LAMPS_RESET;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: begin
          state   <= ALLRED;
          timer   <= ALLRED_LOAD;
          emg_act <= 1'b0;
          lamps   <= LAMPS_RESET;
        end
      endcase
    end
  end

  assign phase = state;
  assign grn   = lamps.grn;
  assign yel   = lamps.yel;
  assign red   = lamps.red;

endmodule

// File: tb/tb_lane_phase_sequencer.sv
// Self-checking bench for lane_phase_sequencer: directed test-plan scenarios plus a
// randomized run compared every cycle against a phase/elapsed-time behavioural model.
module tb_lane_phase_sequencer;

  localparam int T_MIN    = 4;
  localparam int T_EXT    = 2;
  localparam int T_YELLOW = 2;
  localparam int T_ALLRED = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] den [4];
  logic       emg_req = 1'b0;
  logic [1:0] emg_lane = 2'd0;
  logic [1:0] sel;
  logic [3:0] grn;
  logic [3:0] yel;
  logic [3:0] red;
  logic [1:0] phase;
  logic       emg_act;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: phase (0 allred, 1 green, 2 yellow), lane, cycles spent in phase, green length.
  int m_phase;
  int m_sel;
  int m_el;
  int m_dur;
  bit m_emg;

  lane_phase_sequencer #(
    .TW(8), .T_MIN(T_MIN), .T_EXT(T_EXT), .T_YELLOW(T_YELLOW), .T_ALLRED(T_ALLRED)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .den1(den[0]), .den2(den[1]), .den3(den[2]), .den4(den[3]),
    .emg_req(emg_req), .emg_lane(emg_lane),
    .sel(sel), .grn(grn), .yel(yel), .red(red), .phase(phase), .emg_act(emg_act)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_sel   = 3;
    m_el    = 0;
    m_dur   = 0;
    m_emg   = 1'b0;
  endtask

  // Advance the model by one clock using the inputs that the coming edge will see.
  task automatic model_step();
    bit found;
    bit trunc;
    bit hold;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_el++;
    case (m_phase)
      0: if (m_el >= T_ALLRED) begin
        if (emg_req) begin
          m_sel = int'(emg_lane);
          m_emg = 1'b1;
        end else begin
          found = 1'b0;
          for (int i = 1; i <= 4; i++) begin
            if (!found && den[(m_sel + i) % 4] != 0) begin
              m_sel = (m_sel + i) % 4;
              found = 1'b1;
            end
          end
          if (!found) m_sel = (m_sel + 1) % 4;
        end
        m_dur   = T_MIN + int'(den[m_sel]) * T_EXT;
        m_phase = 1;
        m_el    = 0;
      end
      1: begin
        trunc = emg_req && !m_emg && int'(emg_lane) != m_sel;
        hold  = emg_req && (m_emg || int'(emg_lane) == m_sel);
        if (emg_req && int'(emg_lane) == m_sel) m_emg = 1'b1;
        if (trunc || (m_el >= m_dur && !hold)) begin
          m_phase = 2;
          m_el    = 0;
          m_emg   = 1'b0;
        end
      end
      default: if (m_el >= T_YELLOW) begin
        m_phase = 0;
        m_el    = 0;
      end
    endcase
  endtask

  task automatic compare_model();
    logic [3:0] oh;
    logic [3:0] e_grn;
    logic [3:0] e_yel;
    logic [3:0] e_red;
    bit excl;
    oh    = 4'b0001 << m_sel;
    e_grn = (m_phase == 1) ? oh : 4'h0;
    e_yel = (m_phase == 2) ? oh : 4'h0;
    e_red = (m_phase == 0) ? 4'hF : ~oh;
    check("phase", 32'(phase), 32'(m_phase));
    check("sel", 32'(sel), 32'(m_sel));
    check("grn", 32'(grn), 32'(e_grn));
    check("yel", 32'(yel), 32'(e_yel));
    check("red", 32'(red), 32'(e_red));
    check("emg_act", 32'(emg_act), 32'(m_emg));
    excl = 1'b1;
    for (int l = 0; l < 4; l++) begin
      if (int'(grn[l]) + int'(yel[l]) + int'(red[l]) != 1) excl = 1'b0;
    end
    check("one_lamp_per_lane", 32'(excl), 32'd1);
    check("grn_at_most_one", 32'($countones(grn) <= 1), 32'd1);
    if ((grn | yel) != 4'h0) check("sel_matches_lamp", 32'(grn | yel), 32'(4'b0001 << sel));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    compare_model();
  endtask

  task automatic run_to(input int k);
    while (cyc < k) tick();
  endtask

  task automatic expect_at(input string name, input int k, input int exp_phase, input int exp_sel);
    run_to(k);
    check({name, "_phase"}, 32'(phase), 32'(exp_phase));
    check({name, "_sel"}, 32'(sel), 32'(exp_sel));
  endtask

  task automatic set_den(input int d0, input int d1, input int d2, input int d3);
    den[0] = 2'(d0);
    den[1] = 2'(d1);
    den[2] = 2'(d2);
    den[3] = 2'(d3);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    emg_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    set_den(3, 0, 1, 2);
    model_reset();
    do_reset();
    check("reset_sel", 32'(sel), 32'd3);
    check("reset_red", 32'(red), 32'hF);
    check("reset_phase", 32'(phase), 32'd0);

    // Density-sized round robin with lane 2 skipped.
    expect_at("rr_g0_start", 1, 1, 0);
    check("rr_g0_grn", 32'(grn), 32'h1);
    expect_at("rr_g0_end", 10, 1, 0);
    expect_at("rr_y0", 11, 2, 0);
    check("rr_y0_yel", 32'(yel), 32'h1);
    expect_at("rr_ar", 13, 0, 0);
    expect_at("rr_g2_start", 14, 1, 2);
    expect_at("rr_g2_end", 19, 1, 2);
    expect_at("rr_y2", 20, 2, 2);
    expect_at("rr_g3_start", 23, 1, 3);
    expect_at("rr_g3_end", 30, 1, 3);
    expect_at("rr_y3", 31, 2, 3);
    expect_at("rr_g0_again", 34, 1, 0);

    // Density drop mid-green must not shorten the running green.
    do_reset();
    run_to(1);
    den[0] = 2'd0;
    expect_at("den_latch_end", 10, 1, 0);
    expect_at("den_latch_y", 11, 2, 0);
    set_den(3, 0, 1, 2);

    // Emergency truncation, hold, then round robin resumes after the emergency lane.
    do_reset();
    run_to(2);
    emg_req = 1'b1;
    emg_lane = 2'd2;
    expect_at("emg_trunc_y", 3, 2, 0);
    expect_at("emg_ar", 5, 0, 0);
    expect_at("emg_g", 6, 1, 2);
    check("emg_act_set", 32'(emg_act), 32'd1);
    expect_at("emg_hold", 25, 1, 2);
    check("emg_act_hold", 32'(emg_act), 32'd1);
    emg_req = 1'b0;
    expect_at("emg_release_y", 26, 2, 2);
    expect_at("emg_resume", 29, 1, 3);
    check("emg_act_clear", 32'(emg_act), 32'd0);

    // Idle rotation with every lane empty: 7-cycle period, minimum green.
    set_den(0, 0, 0, 0);
    do_reset();
    expect_at("idle_g0", 1, 1, 0);
    expect_at("idle_g0_end", 4, 1, 0);
    expect_at("idle_y0", 5, 2, 0);
    expect_at("idle_ar", 7, 0, 0);
    expect_at("idle_g1", 8, 1, 1);
    expect_at("idle_g2", 15, 1, 2);
    expect_at("idle_g3", 22, 1, 3);
    expect_at("idle_g0b", 29, 1, 0);

    // Asynchronous reset in the middle of yellow.
    set_den(3, 0, 1, 2);
    do_reset();
    expect_at("mid_y", 11, 2, 0);
    rst_n = 1'b0;
    #1;
    check("async_grn", 32'(grn), 32'h0);
    check("async_yel", 32'(yel), 32'h0);
    check("async_red", 32'(red), 32'hF);
    check("async_sel", 32'(sel), 32'd3);
    tick();
    rst_n = 1'b1;
    cyc = 0;
    expect_at("post_reset_g", 1, 1, 0);

    // Randomized density/emergency run checked against the model every cycle.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 7) == 0) den[$urandom_range(0, 3)] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) set_den(0, 0, 0, 0);
      if ($urandom_range(0, 39) == 0) emg_req = ~emg_req;
      if ($urandom_range(0, 9) == 0) emg_lane = 2'($urandom_range(0, 3));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
